// File: rtl/multiciclo_hs.sv
// multiciclo_hs: multicycle RV32I-subset core with a req/ready memory port.
// One unified instruction/data memory sits outside on the handshake port;
// any opcode, funct or alignment fault parks the core in HALT until reset.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | request word at PC, wait for mem_ready, latch Instr
// DECODE | latch A/B from the register file and the immediate, vet opcode
// EXEC   | ALU op / address calc / branch / jump / lui
// MEM    | data access at ALUOut, held until mem_ready
// WB     | write ALUOut or MDR to rd, advance PC
// HALT   | trap raised, PC/Instr frozen, no requests
module multiciclo_hs #(
  parameter int unsigned ADDR_W        = 11,
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter bit          REG_ZERO_HARD = 1'b1
) (
  input  logic              clockCPU,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        regin,
  output logic [31:0]       regout,
  output logic [31:0]       PC,
  output logic [31:0]       Instr,
  output logic [3:0]        estado,
  output logic              trap
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_HALT   = 4'd15
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic        trap_q, trap_d;

  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // instruction fields
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_r, r_legal, is_addi, is_lw, is_sw, is_br, is_jal, is_jalr, is_lui;
  logic legal;

  assign is_r    = (opcode == 7'h33);
  assign r_legal = is_r && (((funct7 == 7'h00) && ((funct3 == 3'd0) || (funct3 == 3'd2) ||
                                                   (funct3 == 3'd6) || (funct3 == 3'd7))) ||
                            ((funct7 == 7'h20) && (funct3 == 3'd0)));
  assign is_addi = (opcode == 7'h13) && (funct3 == 3'd0);
  assign is_lw   = (opcode == 7'h03) && (funct3 == 3'd2);
  assign is_sw   = (opcode == 7'h23) && (funct3 == 3'd2);
  assign is_br   = (opcode == 7'h63) && ((funct3 == 3'd0) || (funct3 == 3'd1));
  assign is_jal  = (opcode == 7'h6F);
  assign is_jalr = (opcode == 7'h67) && (funct3 == 3'd0);
  assign is_lui  = (opcode == 7'h37);
  assign legal   = r_legal | is_addi | is_lw | is_sw | is_br | is_jal | is_jalr | is_lui;

  // register file read ports; x0 forced to zero when hard-wired
  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (REG_ZERO_HARD && (rs1 == 5'd0)) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (REG_ZERO_HARD && (rs2 == 5'd0)) ? 32'd0 : rf_q[rs2];
  assign regout  = (REG_ZERO_HARD && (regin == 5'd0)) ? 32'd0 : rf_q[regin];

  // immediate selection by instruction format, sign-extended
  logic [31:0] imm_sel;
  always_comb begin
    imm_sel = {{20{ir_q[31]}}, ir_q[31:20]};
    if (is_sw)
      imm_sel = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    else if (is_br)
      imm_sel = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    else if (is_jal)
      imm_sel = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    else if (is_lui)
      imm_sel = {ir_q[31:12], 12'd0};
  end

  // R-type ALU result from the operands latched in DECODE
  logic [31:0] r_result;
  always_comb begin
    case (funct3)
      3'd0:    r_result = funct7[5] ? (a_q - b_q) : (a_q + b_q);
      3'd2:    r_result = {31'd0, ($signed(a_q) < $signed(b_q))};
      3'd6:    r_result = a_q | b_q;
      3'd7:    r_result = a_q & b_q;
      default: r_result = a_q + b_q;
    endcase
  end

  logic [31:0] a_plus_imm, pc_plus_4, pc_plus_imm;
  logic        br_taken;
  assign a_plus_imm  = a_q + imm_q;
  assign pc_plus_4   = pc_q + 32'd4;
  assign pc_plus_imm = pc_q + imm_q;
  assign br_taken    = (funct3 == 3'd0) ? (a_q == b_q) : (a_q != b_q);

  // next-state and datapath update for the multicycle sequencer
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    trap_d   = trap_q;
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = 32'd0;
    case (state_q)
      S_FETCH: begin
        // a misaligned PC never reaches the memory port
        if (pc_q[1:0] != 2'b00) begin
          state_d = S_HALT;
          trap_d  = 1'b1;
        end else if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs1_val;
        b_d   = rs2_val;
        imm_d = imm_sel;
        if (!legal) begin
          state_d = S_HALT;
          trap_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          alu_d   = r_result;
          state_d = S_WB;
        end else if (is_addi) begin
          alu_d   = a_plus_imm;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          alu_d = a_plus_imm;
          if (a_plus_imm[1:0] != 2'b00) begin
            state_d = S_HALT;
            trap_d  = 1'b1;
          end else begin
            state_d = S_MEM;
          end
        end else if (is_br) begin
          pc_d    = br_taken ? pc_plus_imm : pc_plus_4;
          state_d = S_FETCH;
        end else if (is_jal) begin
          rf_we    = 1'b1;
          rf_wdata = pc_plus_4;
          pc_d     = pc_plus_imm;
          state_d  = S_FETCH;
        end else if (is_jalr) begin
          // bit 1 of the target is left alone; FETCH traps on it
          rf_we    = 1'b1;
          rf_wdata = pc_plus_4;
          pc_d     = a_plus_imm & ~32'd1;
          state_d  = S_FETCH;
        end else if (is_lui) begin
          rf_we    = 1'b1;
          rf_wdata = imm_q;
          pc_d     = pc_plus_4;
          state_d  = S_FETCH;
        end else begin
          state_d = S_HALT;
          trap_d  = 1'b1;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_lw) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            pc_d    = pc_plus_4;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_wdata = is_lw ? mdr_q : alu_q;
        pc_d     = pc_plus_4;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        trap_d  = 1'b1;
      end
    endcase
  end

  // sequencer and datapath registers
  always_ff @(posedge clockCPU or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      imm_q   <= 32'd0;
      alu_q   <= 32'd0;
      mdr_q   <= 32'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      trap_q  <= trap_d;
    end
  end

  // register file write port; writes to a hard-wired x0 are dropped
  always_ff @(posedge clockCPU or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (rf_we && !(REG_ZERO_HARD && (rf_waddr == 5'd0))) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Memory port decoded from registered state: address/we/wdata come from
  // PC, ALUOut, B and Instr, none of which move while a request waits.
  // Gating with reset_n drops a pending request the instant reset asserts.
  assign mem_req   = reset_n & (((state_q == S_FETCH) && (pc_q[1:0] == 2'b00)) ||
                                (state_q == S_MEM));
  assign mem_we    = (state_q == S_MEM) && is_sw;
  assign mem_addr  = (state_q == S_MEM) ? alu_q[ADDR_W+1:2] : pc_q[ADDR_W+1:2];
  assign mem_wdata = b_q;

  assign PC     = pc_q;
  assign Instr  = ir_q;
  assign estado = state_q;
  assign trap   = trap_q;

endmodule
